// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO definitions for the RISC-V core peripherals.
//   - Address constants for the UART control/status register, the UART
//     transmit register, the cycle-counter reset register and the LED register.
//   - State encoding for the UART transmit store queue output FSM.
package riscv_mmio_pkg;

    localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;
    localparam logic [31:0] CNT_RST_ADDR   = 32'h8000_0018;
    localparam logic [31:0] LED_ADDR       = 32'h8000_0030;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO.
//   clk      in   core clock, all state on rising edge
//   rst_n    in   async active-low reset (pointers and count only)
//   push_i   in   write wdata_i this edge (ignored when full)
//   wdata_i  in   DATA_W write data
//   pop_i    in   advance the read pointer this edge (ignored when empty)
//   rdata_o  out  DATA_W head entry (valid when ~empty_o)
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  $clog2(DEPTH)+1 entries held
module sync_fifo
    import riscv_mmio_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: stale entries are never observable because
    // the read side is gated by count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_store_queue.sv
// Buffers CPU stores to the UART transmit register and feeds them to the
// UART transmitter through a valid/ready port.
//   clk          in   core clock
//   rst_n        in   async active-low reset
//   uart_we      in   store to the UART TX register this cycle
//   wdata        in   DATA_W store data low byte
//   stall        out  hold the store in the pipeline (uart_we & full)
//   tx_data      out  DATA_W byte presented to the transmitter (registered)
//   tx_valid     out  tx_data valid (registered)
//   tx_ready     in   transmitter accepts tx_data this cycle
//   full         out  FIFO storage full
//   empty        out  nothing pending (FIFO empty and tx_valid low)
//   mmio_tx_rdy  out  ~full, status bit 0 of the control/status read
//   pending      out  bytes held: FIFO count + tx_valid
module uart_tx_store_queue
    import riscv_mmio_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_we,
    input  logic [DATA_W-1:0]          wdata,
    output logic                       stall,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       full,
    output logic                       empty,
    output logic                       mmio_tx_rdy,
    output logic [$clog2(DEPTH)+1:0]   pending
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = CW + 1;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CW-1:0]     fifo_count;

    // Stall depends only on full, so a pop in the same cycle never admits
    // the store; it enters on the following cycle.
    assign fifo_push = uart_we & ~fifo_full;
    assign stall     = uart_we &  fifo_full;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The pop decision uses the pre-edge FIFO state; a byte pushed into an
    // empty FIFO is loaded one cycle later (no bypass path).
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        fifo_pop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_rdata;
                    state_d   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        tx_data_d = fifo_rdata;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    // tx_valid is the state register itself: SEND means a byte is presented.
    assign tx_valid    = (state_q == TX_SEND);
    assign tx_data     = tx_data_q;
    assign full        = fifo_full;
    assign empty       = fifo_empty & ~tx_valid;
    assign mmio_tx_rdy = ~fifo_full;
    assign pending     = PW'(fifo_count) + PW'(tx_valid);

endmodule

// File: tb/tb_uart_tx_store_queue.sv
module tb_uart_tx_store_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int PW     = $clog2(DEPTH) + 2;

    logic              clk;
    logic              rst_n;
    logic              uart_we;
    logic [DATA_W-1:0] wdata;
    logic              stall;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              full;
    logic              empty;
    logic              mmio_tx_rdy;
    logic [PW-1:0]     pending;

    uart_tx_store_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_we     (uart_we),
        .wdata       (wdata),
        .stall       (stall),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .full        (full),
        .empty       (empty),
        .mmio_tx_rdy (mmio_tx_rdy),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] d;
        logic              rdy;
        logic              ev;    // expected tx_valid before the edge
        logic [DATA_W-1:0] ed;    // expected tx_data (checked when ev)
        logic              es;    // expected stall
        logic [PW-1:0]     ep;    // expected pending
    } vec_t;

    vec_t              tbl[$];
    logic [DATA_W-1:0] rxq[$];
    logic              chk_stable = 1'b0;
    logic              prev_v = 1'b0, prev_r = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1. Inputs are applied, outputs are
    // sampled one unit later, then the clock edge is taken.
    task automatic cyc(input logic we, input logic [DATA_W-1:0] d, input logic rdy,
                       output logic stl);
        uart_we  = we;
        wdata    = d;
        tx_ready = rdy;
        #1;
        stl = stall;
        if (chk_stable && prev_v && !prev_r) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_d);
        end
        prev_v = tx_valid;
        prev_r = tx_ready;
        prev_d = tx_data;
        if (tx_valid && tx_ready) rxq.push_back(tx_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        uart_we  = 1'b0;
        wdata    = '0;
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rxq.delete();
        prev_v = 1'b0;
        prev_r = 1'b0;
    endtask

    task automatic run_table(input string name);
        logic s;
        for (int i = 0; i < tbl.size(); i++) begin
            uart_we  = tbl[i].we;
            wdata    = tbl[i].d;
            tx_ready = tbl[i].rdy;
            #1;
            check($sformatf("%s[%0d].valid", name, i), tx_valid, tbl[i].ev);
            if (tbl[i].ev)
                check($sformatf("%s[%0d].data", name, i), tx_data, tbl[i].ed);
            check($sformatf("%s[%0d].stall", name, i), stall, tbl[i].es);
            check($sformatf("%s[%0d].pending", name, i), pending, tbl[i].ep);
            check($sformatf("%s[%0d].empty", name, i), empty, (tbl[i].ep == 0));
            @(posedge clk);
            #1;
        end
        s = 1'b0;
        uart_we = s;
    endtask

    task automatic push_bytes(input logic [DATA_W-1:0] first, input int n, input string name);
        logic s;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, first + DATA_W'(i), 1'b0, s);
            check($sformatf("%s.fill_stall%0d", name, i), s, 0);
        end
    endtask

    task automatic drain_and_compare(input logic [DATA_W-1:0] first, input int n, input string name);
        logic s;
        int   budget;
        budget = 0;
        while (rxq.size() < n && budget < 60) begin
            cyc(1'b0, '0, 1'b1, s);
            budget++;
        end
        check({name, ".rx_count"}, rxq.size(), n);
        for (int i = 0; i < n && i < rxq.size(); i++)
            check($sformatf("%s.rx%0d", name, i), rxq[i], first + DATA_W'(i));
    endtask

    initial begin
        logic s;
        int   idx;
        int   budget;

        // Reset values
        do_reset();
        #1;
        check("rst.tx_valid", tx_valid, 0);
        check("rst.tx_data", tx_data, 0);
        check("rst.full", full, 0);
        check("rst.empty", empty, 1);
        check("rst.pending", pending, 0);
        check("rst.stall", stall, 0);
        check("rst.mmio_tx_rdy", mmio_tx_rdy, 1);
        @(posedge clk);
        #1;

        // Asynchronous reset with 3 bytes held and tx_valid high
        push_bytes(8'hA0, 3, "t1");
        uart_we = 1'b0;
        #1;
        check("t1.pre_pending", pending, 3);
        check("t1.pre_valid", tx_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t1.tx_valid", tx_valid, 0);
        check("t1.pending", pending, 0);
        check("t1.empty", empty, 1);
        check("t1.mmio_tx_rdy", mmio_tx_rdy, 1);
        check("t1.full", full, 0);

        // Single store 0x41, tx_ready=1: valid one cycle after the push edge
        do_reset();
        tbl.delete();
        tbl.push_back('{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 5'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0});
        run_table("t2");

        // Streaming 0x10..0x1F with tx_ready held high
        do_reset();
        tbl.delete();
        tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0});
        tbl.push_back('{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1});
        for (int k = 2; k < 16; k++)
            tbl.push_back('{1'b1, 8'h10 + 8'(k), 1'b1, 1'b1, 8'h10 + 8'(k - 2), 1'b0, 5'd2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h1E, 1'b0, 5'd2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h1F, 1'b0, 5'd1});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0});
        run_table("t4");

        // Fill: 9 stores (8 in FIFO + 1 in output register), then a refused store
        do_reset();
        push_bytes(8'h01, 9, "t3");
        check("t3.full", full, 1);
        check("t3.pending", pending, 9);
        check("t3.mmio_tx_rdy", mmio_tx_rdy, 0);
        cyc(1'b1, 8'h0A, 1'b0, s);
        check("t3.stall_full", s, 1);
        check("t3.no_write", pending, 9);
        cyc(1'b1, 8'h0A, 1'b1, s);
        check("t3.stall_on_pop", s, 1);
        cyc(1'b1, 8'h0A, 1'b1, s);
        check("t3.stall_dropped", s, 0);
        drain_and_compare(8'h01, 10, "t3");
        check("t3.empty_end", empty, 1);

        // tx_ready toggling while 12 bytes are pushed; pointers wrap
        do_reset();
        chk_stable = 1'b1;
        idx = 0;
        budget = 0;
        while ((idx < 12 || rxq.size() < 12) && budget < 100) begin
            cyc(idx < 12, 8'h20 + 8'(idx), budget[0] == 1'b0, s);
            if (idx < 12 && !s) idx++;
            budget++;
        end
        chk_stable = 1'b0;
        check("t5.pushed", idx, 12);
        check("t5.rx_count", rxq.size(), 12);
        for (int i = 0; i < 12 && i < rxq.size(); i++)
            check($sformatf("t5.rx%0d", i), rxq[i], 8'h20 + 8'(i));

        // Full queue with a store and tx_ready in the same cycle
        do_reset();
        push_bytes(8'h30, 9, "t6");
        check("t6.full", full, 1);
        cyc(1'b1, 8'h39, 1'b1, s);
        check("t6.stall_same_cycle", s, 1);
        check("t6.pending_after_pop", pending, 8);
        cyc(1'b1, 8'h39, 1'b0, s);
        check("t6.accepted", s, 0);
        check("t6.pending_back", pending, 9);
        check("t6.full_again", full, 1);
        drain_and_compare(8'h30, 10, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
